alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised, sequential successor to the single-cycle datapath ALU.
- Covers the full RV32I ALU operation set plus iterative multiply/divide (MUL, MULHU, DIVU, REMU).
- Uses a start/busy/done handshake and a registered result.
- Sits in the execute stage; the control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from ALUop2 (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; operands and ALUctrl sampled on the same edge.
- ALUop1  in  WIDTH  operand A.
- ALUop2  in  WIDTH  operand B.
- ALUctrl  in  4  operation select.
- busy  out  1  high while an iterative operation is in progress.
- done  out  1  one-cycle pulse; ALUout and EQ valid from this cycle.
- ALUout  out  WIDTH  registered result; held until the next accepted start.
- EQ  out  1  registered (ALUop1 == ALUop2) from the accepted request.

Behaviour:
- Reset (async, any state): state=IDLE; ALUout=0, EQ=0, busy=0, done=0; internal accumulator, quotient and counter all cleared.
- An in-flight operation is abandoned on reset and no done is produced for it.
- States: IDLE, RUN, DONE.
- Start acceptance: start is accepted only in IDLE or DONE. It is ignored in RUN, with no queuing.
- ALUctrl encoding, single-cycle ops:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU.
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - SLT/SLTU produce 1 or 0, zero-extended.
  - Shifts use ALUop2[SHW-1:0] only; upper bits are ignored.
  - Path: accepted start -> result registered on that edge; state=DONE; done=1 in the next cycle (latency 1).
- ALUctrl encoding, iterative ops:
  - 10 MUL (low WIDTH bits of unsigned product), 11 MULHU (high WIDTH bits).
  - 12 DIVU, 13 REMU.
  - Path: accepted start -> state=RUN, busy=1, counter=WIDTH.
  - Multiply: one shift-add step per cycle; 2*WIDTH-bit product register.
  - Divide: one restoring shift-subtract step per cycle.
  - Counter decrements each RUN cycle. When it reaches 0, the result is registered, state=DONE, busy=0, done=1.
  - done asserts exactly WIDTH+1 cycles after the accepting edge. busy is high for the WIDTH cycles in between.
- ALUctrl 14, 15: result 0, handled as single-cycle.
- Divide by zero is detected at start and completes in 1 cycle:
  - DIVU returns all ones.
  - REMU returns ALUop1.
- Arithmetic is modulo 2^WIDTH; no overflow flags.
- DONE state:
  - done=1 for exactly one cycle, then the state returns to IDLE unless start is high that cycle.
  - start in DONE is accepted (back-to-back issue), so done can be high in consecutive cycles for consecutive single-cycle ops.
- ALUout and EQ change only on the edge that registers a new result. They are stable during RUN and hold the previous result.
- Operands change freely after the accepting edge; the block holds internal copies.

Test Plan:
- Reset mid-operation: issue MUL 0xFFFFFFFF*0xFFFFFFFF, assert rst at cycle 10 -> busy=0, done never pulses, ALUout=0.
- Then issue ADD 5+7 -> done next cycle, ALUout=12, EQ=0.
- Single-cycle ops, WIDTH=32, issued back-to-back:
  - SUB 3-5 -> 0xFFFFFFFE.
  - SRA 0x80000000 by 0x24 (shift 4) -> 0xF8000000.
  - SLT 0xFFFFFFFF,1 -> 1.
  - SLTU same operands -> 0.
  - Expect one done per op in consecutive cycles.
- MUL and MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE.
  - Check busy high for exactly 32 cycles and done at cycle 33 after start.
- DIVU/REMU 100/7 -> 14 and 2.
  - DIVU 5/0 -> 0xFFFFFFFF with 1-cycle latency.
  - REMU 5/0 -> 5.
- Busy rejection: pulse start with ADD during RUN of a DIVU -> ignored; DIVU result unaffected; EQ reflects the DIVU operands (ADD 9,9 ignored, DIVU 6,6 -> EQ=1).
- Parameter sweep at WIDTH=8: MUL 0x0F*0x11 -> 0xFF with done 9 cycles after start; SLL by 0x0B uses 3 bits (shift 3).

Source files
------------

// File: rtl/alu_iter.sv
// RV32I ALU plus iterative MUL/MULHU/DIVU/REMU. Single-cycle ops finish 1 cycle after start; iterative ops finish WIDTH+1 cycles after start.
// busy is high for the whole iteration; start is accepted only in IDLE or DONE, and a start during RUN is dropped.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ALUop1,
    input  logic [WIDTH-1:0] ALUop2,
    input  logic [3:0]       ALUctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUout,
    output logic             EQ
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [3:0]         op;
    logic               eq_pend;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;

    logic               accept, is_mul, is_div, div0, go_iter, op_is_mul;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   single_res, iter_res;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;
    logic               fits;

    assign accept    = start && (state != RUN);
    assign is_mul    = (ALUctrl == 4'd10) || (ALUctrl == 4'd11);
    assign is_div    = (ALUctrl == 4'd12) || (ALUctrl == 4'd13);
    assign div0      = is_div && (ALUop2 == '0);
    assign go_iter   = (is_mul || is_div) && !div0;
    assign op_is_mul = (op == 4'd10) || (op == 4'd11);
    assign shamt     = ALUop2[SHW-1:0];

    always_comb begin
        single_res = '0;
        case (ALUctrl)
            4'd0:  single_res = ALUop1 + ALUop2;
            4'd1:  single_res = ALUop1 - ALUop2;
            4'd2:  single_res = ALUop1 << shamt;
            4'd3:  single_res[0] = $signed(ALUop1) < $signed(ALUop2);
            4'd4:  single_res[0] = ALUop1 < ALUop2;
            4'd5:  single_res = ALUop1 ^ ALUop2;
            4'd6:  single_res = ALUop1 >> shamt;
            4'd7:  single_res = $signed(ALUop1) >>> shamt;
            4'd8:  single_res = ALUop1 | ALUop2;
            4'd9:  single_res = ALUop1 & ALUop2;
            // Only reachable with a zero divisor; real divides go iterative.
            4'd12: single_res = '1;
            4'd13: single_res = ALUop1;
            default: single_res = '0;
        endcase
    end

    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: remainder lives in acc[WIDTH-1:0], dividend shifts out of quo.
    assign rem_sh  = {acc[WIDTH-1:0], quo[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, opb};
    assign fits    = !diff[WIDTH];
    assign rem_nxt = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], fits};

    always_comb begin
        iter_res = rem_nxt;
        case (op)
            4'd10:   iter_res = mul_nxt[WIDTH-1:0];
            4'd11:   iter_res = mul_nxt[2*WIDTH-1:WIDTH];
            4'd12:   iter_res = quo_nxt;
            default: iter_res = rem_nxt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = go_iter ? RUN : DONE;
                else        state_nxt = IDLE;
            end
            RUN:     if (cnt == CW'(1)) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUout  <= '0;
            EQ      <= 1'b0;
            op      <= '0;
            eq_pend <= 1'b0;
            acc     <= '0;
            quo     <= '0;
            opb     <= '0;
            cnt     <= '0;
        end else if (accept) begin
            op      <= ALUctrl;
            eq_pend <= (ALUop1 == ALUop2);
            quo     <= ALUop1;
            acc     <= is_mul ? {{WIDTH{1'b0}}, ALUop2} : '0;
            opb     <= is_mul ? ALUop1 : ALUop2;
            if (go_iter) begin
                cnt <= CW'(WIDTH);
            end else begin
                ALUout <= single_res;
                EQ     <= (ALUop1 == ALUop2);
            end
        end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
            if (op_is_mul) begin
                acc <= mul_nxt;
            end else begin
                acc[WIDTH-1:0] <= rem_nxt;
                quo            <= quo_nxt;
            end
            if (cnt == CW'(1)) begin
                ALUout <= iter_res;
                EQ     <= eq_pend;
            end
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s32, s8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [3:0]  c32, c8;
    logic        busy32, done32, eq32, busy8, done8, eq8;
    logic [31:0] o32;
    logic [7:0]  o8;

    int checks = 0;
    int errors = 0;

    alu_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(s32), .ALUop1(a32), .ALUop2(b32), .ALUctrl(c32),
        .busy(busy32), .done(done32), .ALUout(o32), .EQ(eq32)
    );

    alu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .ALUop1(a8), .ALUop2(b8), .ALUctrl(c8),
        .busy(busy8), .done(done8), .ALUout(o8), .EQ(eq8)
    );

    function automatic logic [31:0] model(input int w, input logic [3:0] c,
                                          input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, ua, ub, r;
        longint          sa, sb;
        int              sh;
        m  = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
        ua = {32'b0, a} & m;
        ub = {32'b0, b} & m;
        sh = int'(ub % 64'(w));
        sa = (((ua >> (w - 1)) & 1) == 1) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = (((ub >> (w - 1)) & 1) == 1) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        case (c)
            4'd0:  r = ua + ub;
            4'd1:  r = ua - ub;
            4'd2:  r = ua << sh;
            4'd3:  r = (sa < sb) ? 1 : 0;
            4'd4:  r = (ua < ub) ? 1 : 0;
            4'd5:  r = ua ^ ub;
            4'd6:  r = ua >> sh;
            4'd7:  r = $unsigned(sa >>> sh);
            4'd8:  r = ua | ub;
            4'd9:  r = ua & ub;
            4'd10: r = ua * ub;
            4'd11: r = (ua * ub) >> w;
            4'd12: r = (ub == 0) ? m : ua / ub;
            4'd13: r = (ub == 0) ? ua : ua % ub;
            default: r = 0;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    function automatic logic [31:0] rd_out(input int w);
        return (w == 32) ? o32 : {24'b0, o8};
    endfunction
    function automatic logic rd_eq(input int w);
        return (w == 32) ? eq32 : eq8;
    endfunction
    function automatic logic rd_done(input int w);
        return (w == 32) ? done32 : done8;
    endfunction
    function automatic logic rd_busy(input int w);
        return (w == 32) ? busy32 : busy8;
    endfunction

    task automatic drive(input int w, input logic st, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            s32 = st; c32 = c; a32 = a; b32 = b;
        end else begin
            s8 = st; c8 = c; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    // Issues one op and checks latency, busy length, output stability during RUN, result and EQ.
    // inj > 0 pulses a start for ADD 9,9 on that cycle after the accepting edge.
    task automatic op(input int w, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input int inj);
        logic [31:0] m, exp_r, prev_o;
        logic        prev_eq, exp_eq;
        int          lat, cyc, nbusy;
        bit          seen, stable;
        m      = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        exp_r  = model(w, c, a, b);
        exp_eq = ((a & m) == (b & m));
        lat    = (c >= 4'd10 && c <= 4'd13 && !((c == 4'd12 || c == 4'd13) && (b & m) == 0)) ? w + 1 : 1;
        @(negedge clk);
        prev_o  = rd_out(w);
        prev_eq = rd_eq(w);
        drive(w, 1'b1, c, a, b);
        seen = 0; nbusy = 0; stable = 1; cyc = 0;
        while (!seen && cyc < w + 10) begin
            @(negedge clk);
            cyc++;
            if (rd_done(w)) begin
                seen = 1;
            end else begin
                if (rd_busy(w)) nbusy++;
                if (rd_out(w) !== prev_o || rd_eq(w) !== prev_eq) stable = 0;
            end
            if (cyc == 1) drive(w, 1'b0, c, ~a, ~b);
            if (inj > 0 && cyc == inj) drive(w, 1'b1, 4'd0, 32'd9, 32'd9);
            if (inj > 0 && cyc == inj + 1) drive(w, 1'b0, 4'd0, 32'd0, 32'd0);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL w%0d ctrl%0d timeout: done never seen, expected at cycle %0d", w, c, lat);
        end else if (cyc != lat) begin
            errors++;
            $display("FAIL w%0d ctrl%0d latency: got %0d expected %0d", w, c, cyc, lat);
        end
        checks++;
        if (nbusy != lat - 1) begin
            errors++;
            $display("FAIL w%0d ctrl%0d busy cycles: got %0d expected %0d", w, c, nbusy, lat - 1);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL w%0d ctrl%0d hold during run: got changed expected %h/%0b", w, c, prev_o, prev_eq);
        end
        checks++;
        if (rd_out(w) !== exp_r) begin
            errors++;
            $display("FAIL w%0d ctrl%0d result a=%h b=%h: got %h expected %h", w, c, a, b, rd_out(w), exp_r);
        end
        checks++;
        if (rd_eq(w) !== exp_eq) begin
            errors++;
            $display("FAIL w%0d ctrl%0d EQ: got %0b expected %0b", w, c, rd_eq(w), exp_eq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(8, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if ({busy32, done32, eq32, o32} !== 35'd0 || {busy8, done8, eq8, o8} !== 11'd0) begin
            errors++;
            $display("FAIL reset state: got %b/%h %b/%h expected zeros",
                     {busy32, done32, eq32}, o32, {busy8, done8, eq8}, o8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  cs[$];
        logic [31:0] as[$], bs[$];
        logic [31:0] e;
        cs = '{4'd1, 4'd7, 4'd3, 4'd4};
        as = '{32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bs = '{32'd5, 32'h24, 32'd1, 32'd1};
        for (int i = 0; i < 8; i++) begin
            logic [3:0] rc;
            rc = 4'($urandom_range(0, 11));
            if (rc > 4'd9) rc = rc + 4'd4;
            cs.push_back(rc);
            as.push_back($urandom);
            bs.push_back(($urandom_range(0, 3) == 0) ? as[as.size() - 1] : $urandom);
        end
        @(negedge clk);
        drive(32, 1'b1, cs[0], as[0], bs[0]);
        for (int k = 1; k <= cs.size(); k++) begin
            @(negedge clk);
            e = model(32, cs[k-1], as[k-1], bs[k-1]);
            checks++;
            if (done32 !== 1'b1 || o32 !== e || eq32 !== (as[k-1] == bs[k-1])) begin
                errors++;
                $display("FAIL b2b op%0d ctrl%0d: got done=%0b out=%h eq=%0b expected done=1 out=%h eq=%0b",
                         k - 1, cs[k-1], done32, o32, eq32, e, as[k-1] == bs[k-1]);
            end
            if (k < cs.size()) drive(32, 1'b1, cs[k], as[k], bs[k]);
            else               drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
        end
        @(negedge clk);
        checks++;
        if (done32 !== 1'b0) begin
            errors++;
            $display("FAIL done pulse width: got %0b expected 0", done32);
        end
    endtask

    task automatic test_reset_mid_op();
        bit pulsed;
        op(32, 4'd0, 32'd1, 32'd1, 0);
        @(negedge clk);
        drive(32, 1'b1, 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || o32 !== 32'd0 || eq32 !== 1'b0) begin
            errors++;
            $display("FAIL async reset mid-op: got busy=%0b done=%0b out=%h eq=%0b expected 0/0/0/0",
                     busy32, done32, o32, eq32);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulsed = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 || busy32) pulsed = 1;
        end
        checks++;
        if (pulsed) begin
            errors++;
            $display("FAIL abandoned op: got done/busy activity expected none");
        end
        op(32, 4'd0, 32'd5, 32'd7, 0);
    endtask

    task automatic test_mul();
        op(32, 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        op(32, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        op(32, 4'd10, 32'd0, 32'h1234_5678, 0);
    endtask

    task automatic test_div();
        op(32, 4'd12, 32'd100, 32'd7, 0);
        op(32, 4'd13, 32'd100, 32'd7, 0);
        op(32, 4'd12, 32'd5, 32'd0, 0);
        op(32, 4'd13, 32'd5, 32'd0, 0);
        op(32, 4'd12, 32'hFFFF_FFFF, 32'd1, 0);
    endtask

    task automatic test_busy_reject();
        op(32, 4'd12, 32'd6, 32'd6, 5);
    endtask

    task automatic test_width8();
        op(8, 4'd10, 32'h0F, 32'h11, 0);
        op(8, 4'd2, 32'h35, 32'h0B, 0);
        for (int i = 0; i < 20; i++)
            op(8, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 5 == 0) b = b >> $urandom_range(0, 31);
            op(32, c, a, b, 0);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_reset_mid_op();
        test_mul();
        test_div();
        test_busy_reject();
        test_width8();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
